// File: rtl/nv_nvdla_rubik_slcg_ctrl.sv
// rtl/nv_nvdla_rubik_slcg_ctrl.sv - RUBIK SLCG idle-detect / wake sequencer
module nv_nvdla_rubik_slcg_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int HYST_W   = 8,
    parameter int WAKE_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic [NUM_REQ-1:0] req_busy,
    input  logic [NUM_REQ-1:0] wake_req,
    output logic [NUM_REQ-1:0] wake_ack,
    input  logic [HYST_W-1:0]  cfg_idle_hyst,
    input  logic               cfg_force_on,
    output logic               slcg_enable,
    output logic               slcg_gated,
    output logic [CNT_W-1:0]   gate_count
);

    localparam int WL_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
    localparam logic [WL_W-1:0] WAKE_LOAD = WL_W'(WAKE_LAT - 1);

    localparam logic [1:0] ST_ACTIVE   = 2'd0;
    localparam logic [1:0] ST_IDLE_CNT = 2'd1;
    localparam logic [1:0] ST_GATED    = 2'd2;
    localparam logic [1:0] ST_WAKE     = 2'd3;

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [HYST_W-1:0]  idle_cnt;
    logic [HYST_W-1:0]  idle_cnt_next;
    logic [WL_W-1:0]    wake_cnt;
    logic [WL_W-1:0]    wake_cnt_next;
    logic [NUM_REQ-1:0] ack_pend;
    logic               hold;
    logic               ack_ok;

    assign hold = (|req_busy) | (|wake_req) | cfg_force_on;

    // Acks are only allowed once the gated clock is certain to be running.
    assign ack_ok = (state == ST_ACTIVE) || (state == ST_IDLE_CNT) ||
                    ((state == ST_WAKE) && (wake_cnt == '0));

    always_comb begin
        next_state    = state;
        idle_cnt_next = idle_cnt;
        wake_cnt_next = wake_cnt;
        case (state)
            ST_ACTIVE: begin
                if (!hold) begin
                    next_state    = ST_IDLE_CNT;
                    idle_cnt_next = cfg_idle_hyst;
                end
            end
            ST_IDLE_CNT: begin
                if (hold) begin
                    next_state = ST_ACTIVE;
                end else if (idle_cnt == '0) begin
                    next_state = ST_GATED;
                end else begin
                    idle_cnt_next = idle_cnt - HYST_W'(1);
                end
            end
            ST_GATED: begin
                if (hold) begin
                    next_state    = ST_WAKE;
                    wake_cnt_next = WAKE_LOAD;
                end
            end
            default: begin
                if (wake_cnt == '0) begin
                    next_state = ST_ACTIVE;
                end else begin
                    wake_cnt_next = wake_cnt - WL_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state       <= ST_ACTIVE;
            idle_cnt    <= '0;
            wake_cnt    <= '0;
            slcg_enable <= 1'b1;
            slcg_gated  <= 1'b0;
            gate_count  <= '0;
            wake_ack    <= '0;
            ack_pend    <= '0;
        end else begin
            state       <= next_state;
            idle_cnt    <= idle_cnt_next;
            wake_cnt    <= wake_cnt_next;
            slcg_enable <= (next_state != ST_GATED);
            slcg_gated  <= (next_state == ST_GATED);
            if ((state != ST_GATED) && (next_state == ST_GATED) && (gate_count != '1)) begin
                gate_count <= gate_count + CNT_W'(1);
            end
            wake_ack <= wake_req & ~ack_pend & {NUM_REQ{ack_ok}};
            ack_pend <= wake_req & (ack_pend | {NUM_REQ{ack_ok}});
        end
    end

endmodule

// File: tb/tb_nv_nvdla_rubik_slcg_ctrl.sv
// tb/tb_nv_nvdla_rubik_slcg_ctrl.sv - self-checking bench for nv_nvdla_rubik_slcg_ctrl
module tb_nv_nvdla_rubik_slcg_ctrl;

    localparam int WAKE_LAT = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  req_busy;
    logic [3:0]  wake_req;
    logic [3:0]  wake_ack;
    logic [7:0]  cfg_idle_hyst;
    logic        cfg_force_on;
    logic        slcg_enable;
    logic        slcg_gated;
    logic [15:0] gate_count;

    int n_checks;
    int n_fail;

    nv_nvdla_rubik_slcg_ctrl #(
        .NUM_REQ(4), .HYST_W(8), .WAKE_LAT(WAKE_LAT), .CNT_W(16)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .req_busy(req_busy),
        .wake_req(wake_req),
        .wake_ack(wake_ack),
        .cfg_idle_hyst(cfg_idle_hyst),
        .cfg_force_on(cfg_force_on),
        .slcg_enable(slcg_enable),
        .slcg_gated(slcg_gated),
        .gate_count(gate_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: gating happens once the run of consecutive idle cycles
    // outside GATED/WAKE reaches hyst+2; a wake lasts WAKE_LAT cycles.
    int         m_gated;
    int         m_wake_left;
    int         m_run;
    int         m_hyst;
    int         m_cnt;
    logic [3:0] m_pend;
    logic [3:0] m_ack;

    task automatic model(input logic r, input logic [3:0] b, input logic [3:0] w,
                         input int h, input logic f);
        bit hold;
        bit ok;
        if (r) begin
            m_gated = 0; m_wake_left = 0; m_run = 0; m_hyst = 0; m_cnt = 0;
            m_pend = '0; m_ack = '0;
        end else begin
            hold = (b != 0) || (w != 0) || f;
            ok = 0;
            if (m_gated != 0) begin
                if (hold) begin
                    m_gated = 0;
                    m_wake_left = WAKE_LAT;
                end
            end else if (m_wake_left > 0) begin
                ok = (m_wake_left == 1);
                m_wake_left = m_wake_left - 1;
            end else begin
                ok = 1;
                if (hold) m_run = 0;
                else begin
                    if (m_run == 0) m_hyst = h;
                    m_run = m_run + 1;
                    if (m_run == m_hyst + 2) begin
                        m_gated = 1;
                        m_run = 0;
                        if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    end
                end
            end
            m_ack  = w & ~m_pend & {4{ok}};
            m_pend = w & (m_pend | m_ack);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] b, input logic [3:0] w,
                        input int h, input logic f);
        rst = r; req_busy = b; wake_req = w; cfg_idle_hyst = 8'(h); cfg_force_on = f;
        @(posedge clk);
        model(r, b, w, h, f);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  b;
        logic [3:0]  w;
        int          h;
        logic        f;
        logic        en;
        logic        gt;
        logic [3:0]  ack;
        int          cnt;
    } vec_t;

    vec_t vecs[27];

    initial begin
        bit done;
        logic [3:0] wk;
        logic [3:0] bz;
        int hy;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1; req_busy = '0; wake_req = '0; cfg_idle_hyst = 8'd3; cfg_force_on = 1'b0;

        // Reset, idle gating (hyst 3), wake on lane 2, dual ack, busy blip mid-count.
        vecs[0] = '{1'b1, 4'h0, 4'h0, 3, 1'b0, 1'b1, 1'b0, 4'h0, 0};
        for (int i = 1; i <= 4; i++) vecs[i] = '{1'b0, 4'h0, 4'h0, 3, 1'b0, 1'b1, 1'b0, 4'h0, 0};
        vecs[5]  = '{1'b0, 4'h0, 4'h0, 3, 1'b0, 1'b0, 1'b1, 4'h0, 1};
        vecs[6]  = '{1'b0, 4'h0, 4'h0, 3, 1'b0, 1'b0, 1'b1, 4'h0, 1};
        vecs[7]  = '{1'b0, 4'h0, 4'h4, 3, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        vecs[8]  = '{1'b0, 4'h0, 4'h4, 3, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        vecs[9]  = '{1'b0, 4'h0, 4'h4, 3, 1'b0, 1'b1, 1'b0, 4'h4, 1};
        for (int i = 10; i <= 14; i++) vecs[i] = '{1'b0, 4'h0, 4'h4, 3, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        vecs[15] = '{1'b0, 4'h0, 4'h0, 3, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        vecs[16] = '{1'b0, 4'h1, 4'h0, 3, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        vecs[17] = '{1'b0, 4'h0, 4'h9, 3, 1'b0, 1'b1, 1'b0, 4'h9, 1};
        for (int i = 18; i <= 20; i++) vecs[i] = '{1'b0, 4'h0, 4'h0, 3, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        vecs[21] = '{1'b0, 4'h1, 4'h0, 3, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        for (int i = 22; i <= 25; i++) vecs[i] = '{1'b0, 4'h0, 4'h0, 3, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        vecs[26] = '{1'b0, 4'h0, 4'h0, 3, 1'b0, 1'b0, 1'b1, 4'h0, 2};

        for (int i = 0; i < 27; i++) begin
            step(vecs[i].r, vecs[i].b, vecs[i].w, vecs[i].h, vecs[i].f);
            chk($sformatf("vec%0d enable", i), 32'(slcg_enable), 32'(vecs[i].en));
            chk($sformatf("vec%0d gated", i), 32'(slcg_gated), 32'(vecs[i].gt));
            chk($sformatf("vec%0d ack", i), 32'(wake_ack), 32'(vecs[i].ack));
            chk($sformatf("vec%0d count", i), 32'(gate_count), 32'(vecs[i].cnt));
        end

        // Force-on holds the clock for 300 idle cycles, then hyst 0 gates in 2.
        step(1'b1, 4'h0, 4'h0, 0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 4'h0, 4'h0, 0, 1'b1);
            chk("force enable", 32'(slcg_enable), 32'd1);
            chk("force count", 32'(gate_count), 32'd0);
        end
        step(1'b0, 4'h0, 4'h0, 0, 1'b0);
        chk("unforce1 enable", 32'(slcg_enable), 32'd1);
        step(1'b0, 4'h0, 4'h0, 0, 1'b0);
        chk("unforce2 enable", 32'(slcg_enable), 32'd0);
        chk("unforce2 gated", 32'(slcg_gated), 32'd1);
        chk("unforce2 count", 32'(gate_count), 32'd1);

        // Cycle through wake/gate until gate_count reaches 7.
        for (int k = 2; k <= 7; k++) begin
            step(1'b0, 4'h1, 4'h0, 0, 1'b0);
            done = 0;
            for (int t = 0; t < 10 && !done; t++) begin
                step(1'b0, 4'h0, 4'h0, 0, 1'b0);
                if (!slcg_enable) done = 1;
            end
            chk("regate timeout", 32'(done), 32'd1);
            chk("regate count", 32'(gate_count), 32'(k));
        end

        // One-cycle reset while gated, with a wake request pending.
        step(1'b1, 4'h0, 4'h2, 0, 1'b0);
        chk("rst enable", 32'(slcg_enable), 32'd1);
        chk("rst gated", 32'(slcg_gated), 32'd0);
        chk("rst count", 32'(gate_count), 32'd0);
        chk("rst ack", 32'(wake_ack), 32'd0);
        step(1'b0, 4'h0, 4'h2, 0, 1'b0);
        chk("post-rst ack", 32'(wake_ack), 32'h2);

        // Randomized traffic against the reference model.
        step(1'b1, 4'h0, 4'h0, 0, 1'b0);
        wk = '0;
        hy = 2;
        for (int i = 0; i < 3000; i++) begin
            for (int l = 0; l < 4; l++) begin
                if (wk[l]) begin
                    if ($urandom_range(3) == 0) wk[l] = 1'b0;
                end else if ($urandom_range(24) == 0) begin
                    wk[l] = 1'b1;
                end
                bz[l] = ($urandom_range(11) == 0);
            end
            if ($urandom_range(29) == 0) hy = int'($urandom_range(4));
            step(($urandom_range(199) == 0), bz, wk, hy, ($urandom_range(49) == 0));
            chk("rnd enable", 32'(slcg_enable), 32'(m_gated == 0));
            chk("rnd gated", 32'(slcg_gated), 32'(m_gated != 0));
            chk("rnd ack", 32'(wake_ack), 32'(m_ack));
            chk("rnd count", 32'(gate_count), 32'(m_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
